// File: rtl/wo_mac_sched_if.sv
// Bus bundle for wo_mac_sched: pass control, weight-ROM port, hidden-state stream and result stream.
interface wo_mac_sched_if #(
  parameter int D_WL      = 24,
  parameter int UNITS_NUM = 5,
  parameter int ADDR_W    = 8
);
  logic                      start;
  logic                      busy;
  logic                      done;
  logic [ADDR_W-1:0]         w_addr;
  logic [UNITS_NUM*D_WL-1:0] w_data;
  logic [D_WL-1:0]           h_data;
  logic                      h_valid;
  logic                      h_ready;
  logic [UNITS_NUM*D_WL-1:0] y_data;
  logic                      y_valid;
  logic                      y_ready;

  modport slave (
    input  start, w_data, h_data, h_valid, y_ready,
    output busy, done, w_addr, h_ready, y_data, y_valid
  );

  modport master (
    output start, w_data, h_data, h_valid, y_ready,
    input  busy, done, w_addr, h_ready, y_data, y_valid
  );
endinterface

// File: rtl/wo_mac_sched.sv
// Output-layer weight-ROM sequencer and UNITS_NUM-lane fixed-point MAC.
// Optional macro WO_SAT_EN: saturate each accumulator to D_WL bits on output (default: wrap).
module wo_mac_sched #(
  parameter int D_WL      = 24,
  parameter int FRAC      = 12,
  parameter int UNITS_NUM = 5,
  parameter int DEPTH     = 156,
  parameter int ADDR_W    = 8
) (
  input  logic           clk,
  input  logic           rst,
  wo_mac_sched_if.slave  bus
);
  localparam int ACC_WL = 2*D_WL-FRAC+8;
  localparam int MUL_WL = 2*D_WL;
  localparam int SHR_WL = MUL_WL-FRAC;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH-1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t                    r_state;
  logic [ADDR_W-1:0]         r_addr;
  logic                      r_pvld;
  logic                      r_busy;
  logic                      r_done;
  logic                      r_h_ready;
  logic                      r_y_valid;
  logic [UNITS_NUM*D_WL-1:0] r_y;
  logic signed [ACC_WL-1:0]  r_prod [UNITS_NUM];
  logic signed [ACC_WL-1:0]  r_acc  [UNITS_NUM];

  logic signed [MUL_WL-1:0]  w_mul     [UNITS_NUM];
  logic signed [ACC_WL-1:0]  w_prod    [UNITS_NUM];
  logic signed [ACC_WL-1:0]  w_acc_nxt [UNITS_NUM];
  logic [UNITS_NUM*D_WL-1:0] w_y_nxt;
  logic                      w_hs;

  function automatic logic [D_WL-1:0] acc_to_word(input logic signed [ACC_WL-1:0] a);
`ifdef WO_SAT_EN
    logic [ACC_WL-D_WL:0] hi;
    hi = a[ACC_WL-1:D_WL-1];
    if (hi == {(ACC_WL-D_WL+1){a[ACC_WL-1]}}) begin
      return a[D_WL-1:0];
    end else if (a[ACC_WL-1]) begin
      return {1'b1, {(D_WL-1){1'b0}}};
    end else begin
      return {1'b0, {(D_WL-1){1'b1}}};
    end
`else
    return D_WL'(a);
`endif
  endfunction

  // r_h_ready is high exactly while in RUN, so this is the only accepted-row condition
  assign w_hs = bus.h_valid && r_h_ready;

  // Per-lane product, next accumulator value and converted output word
  always_comb begin
    w_mul     = '{default: '0};
    w_prod    = '{default: '0};
    w_acc_nxt = '{default: '0};
    w_y_nxt   = '0;
    for (int u = 0; u < UNITS_NUM; u++) begin
      w_mul[u]     = $signed(bus.h_data) * $signed(bus.w_data[(UNITS_NUM-1-u)*D_WL +: D_WL]);
      w_prod[u]    = {{(ACC_WL-SHR_WL){w_mul[u][MUL_WL-1]}}, w_mul[u][MUL_WL-1:FRAC]};
      w_acc_nxt[u] = r_pvld ? (r_acc[u] + r_prod[u]) : r_acc[u];
      w_y_nxt[(UNITS_NUM-1-u)*D_WL +: D_WL] = acc_to_word(w_acc_nxt[u]);
    end
  end

  // Pass sequencer, product pipeline and accumulators
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_pvld    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_h_ready <= 1'b0;
      r_y_valid <= 1'b0;
      r_y       <= '0;
      for (int u = 0; u < UNITS_NUM; u++) begin
        r_prod[u] <= '0;
        r_acc[u]  <= '0;
      end
    end else begin
      r_done <= 1'b0;
      for (int u = 0; u < UNITS_NUM; u++) begin
        r_acc[u] <= w_acc_nxt[u];
      end
      case (r_state)
        S_IDLE: begin
          r_pvld <= 1'b0;
          if (bus.start) begin
            r_addr    <= '0;
            r_busy    <= 1'b1;
            r_h_ready <= 1'b1;
            r_state   <= S_RUN;
            for (int u = 0; u < UNITS_NUM; u++) begin
              r_prod[u] <= '0;
              r_acc[u]  <= '0;
            end
          end
        end
        S_RUN: begin
          r_pvld <= w_hs;
          if (w_hs) begin
            r_prod <= w_prod;
            if (r_addr == LAST_ADDR) begin
              r_h_ready <= 1'b0;
              r_state   <= S_DRAIN;
            end else begin
              r_addr <= r_addr + ADDR_W'(1);
            end
          end
        end
        // The last product lands in w_acc_nxt this cycle, so the result is taken from it
        S_DRAIN: begin
          r_pvld    <= 1'b0;
          r_y       <= w_y_nxt;
          r_y_valid <= 1'b1;
          r_state   <= S_OUT;
        end
        S_OUT: begin
          if (bus.y_ready) begin
            r_y_valid <= 1'b0;
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_pvld    <= 1'b0;
          r_busy    <= 1'b0;
          r_h_ready <= 1'b0;
          r_y_valid <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.w_addr  = r_addr;
  assign bus.h_ready = r_h_ready;
  assign bus.y_data  = r_y;
  assign bus.y_valid = r_y_valid;
endmodule

// File: tb/tb_wo_mac_sched.sv
// Scoreboard bench for wo_mac_sched: directed scenarios plus randomized passes against a sum-of-products model.
module tb_wo_mac_sched;
  localparam int D_WL   = 24;
  localparam int FRAC   = 12;
  localparam int UNITS  = 5;
  localparam int DEPTH  = 156;
  localparam int ADDR_W = 8;
  localparam int YW     = UNITS*D_WL;

`ifdef WO_SAT_EN
  localparam logic [D_WL-1:0] SAT_EXP = 24'h7FFFFF;
`else
  localparam logic [D_WL-1:0] SAT_EXP = 24'h000000;
`endif

  logic clk;
  logic rst;

  wo_mac_sched_if #(.D_WL(D_WL), .UNITS_NUM(UNITS), .ADDR_W(ADDR_W)) bus ();

  wo_mac_sched #(
    .D_WL(D_WL), .FRAC(FRAC), .UNITS_NUM(UNITS), .DEPTH(DEPTH), .ADDR_W(ADDR_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [D_WL-1:0] rom_w [DEPTH][UNITS];
  logic [D_WL-1:0] hmem  [DEPTH];
  logic [YW-1:0]   exp_q [$];
  int              n_cmp = 0;
  int              n_err = 0;
  bit              exp_done = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational ROM model
  always_comb begin
    bus.w_data = '0;
    for (int u = 0; u < UNITS; u++) begin
      if (int'(bus.w_addr) < DEPTH) bus.w_data[(UNITS-1-u)*D_WL +: D_WL] = rom_w[bus.w_addr][u];
    end
  end

  task automatic check(input string name, input logic [YW-1:0] act, input logic [YW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fill_rows(input logic [YW-1:0] wrow, input logic [D_WL-1:0] hval);
    for (int r = 0; r < DEPTH; r++) begin
      hmem[r] = hval;
      for (int u = 0; u < UNITS; u++) rom_w[r][u] = wrow[(UNITS-1-u)*D_WL +: D_WL];
    end
  endtask

  task automatic fill_random();
    for (int r = 0; r < DEPTH; r++) begin
      hmem[r] = D_WL'($urandom);
      for (int u = 0; u < UNITS; u++) rom_w[r][u] = D_WL'($urandom);
    end
  endtask

  // Reference: per-unit sum over rows of (h*w)>>FRAC, then wrap or clamp to D_WL bits
  function automatic logic [YW-1:0] model_result();
    logic [YW-1:0] y;
    longint s;
    longint lo;
    longint hi;
    lo = -(longint'(1) <<< (D_WL-1));
    hi = (longint'(1) <<< (D_WL-1)) - 1;
    y  = '0;
    for (int u = 0; u < UNITS; u++) begin
      s = 0;
      for (int r = 0; r < DEPTH; r++)
        s += (longint'($signed(hmem[r])) * longint'($signed(rom_w[r][u]))) >>> FRAC;
`ifdef WO_SAT_EN
      if (s > hi) s = hi;
      else if (s < lo) s = lo;
`endif
      y[(UNITS-1-u)*D_WL +: D_WL] = s[D_WL-1:0];
    end
    return y;
  endfunction

  task automatic check_reset(input string tag);
    check({"rst_ctl ", tag}, YW'({bus.busy, bus.done, bus.h_ready, bus.y_valid}), YW'(0));
    check({"rst_addr ", tag}, YW'(bus.w_addr), YW'(0));
    check({"rst_y ", tag}, bus.y_data, YW'(0));
  endtask

  task automatic run_pass(input string tag, input logic [YW-1:0] exp_y, input bit stall,
                          input int abort_row, input int hold_cycles);
    int cyc;
    int row;
    int stalls;
    int lat;
    bit hv;
    logic [YW-1:0] held;
    bus.y_ready = (hold_cycles == 0);
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    if (abort_row < 0) exp_q.push_back(exp_y);
    cyc = 1; row = 0; stalls = 0;
    while (row < DEPTH && cyc < 4*DEPTH) begin
      if (row == abort_row) begin
        bus.h_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_reset(tag);
        return;
      end
      hv = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.h_valid = hv;
      bus.h_data  = hmem[row];
      @(negedge clk);
      check({"addr ", tag}, YW'(bus.w_addr), YW'(row));
      check({"h_ready ", tag}, YW'(bus.h_ready), YW'(1));
      if (hv && bus.h_ready) row++;
      else stalls++;
      @(posedge clk); #1;
      cyc++;
    end
    check({"rows ", tag}, YW'(row), YW'(DEPTH));
    bus.h_valid = 1'b0;
    @(negedge clk);
    check({"drain ", tag}, YW'({bus.y_valid, bus.h_ready, bus.busy}), YW'(3'b001));
    lat = cyc;
    do begin
      @(posedge clk); lat++;
      @(negedge clk);
    end while (!bus.y_valid && lat < cyc + 50);
    check({"latency ", tag}, YW'(lat), YW'(DEPTH + 2 + stalls));
    if (hold_cycles > 0) begin
      held = bus.y_data;
      for (int i = 0; i < hold_cycles; i++) begin
        @(posedge clk); #1 bus.start = (i == 5);
        @(negedge clk);
        check({"hold_y ", tag}, bus.y_data, held);
        check({"hold_vd ", tag}, YW'({bus.y_valid, bus.done}), YW'(2'b10));
      end
      @(posedge clk); #1;
      bus.start   = 1'b0;
      bus.y_ready = 1'b1;
      @(negedge clk);
    end
    lat = 0;
    do begin
      @(negedge clk); lat++;
    end while (bus.busy && lat < 8);
    check({"idle ", tag}, YW'({bus.busy, bus.y_valid}), YW'(0));
    check({"idle_lat ", tag}, YW'(lat), YW'(1));
    @(negedge clk);
    check({"stay_idle ", tag}, YW'({bus.busy, bus.y_valid}), YW'(0));
  endtask

  // Monitor: pops the scoreboard on every accepted result and tracks the done pulse
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_done = 1'b0;
      end else begin
        check("done", YW'(bus.done), YW'(exp_done));
        exp_done = bus.y_valid && bus.y_ready;
        if (exp_done) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL y_data: got %h, expected no result", bus.y_data);
          end else begin
            check("y_data", bus.y_data, exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.h_valid = 1'b0;
    bus.h_data = '0;
    bus.y_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset("init");

    fill_rows({5{24'h001000}}, 24'h000800);
    run_pass("basic", {5{24'h04E000}}, 1'b0, -1, 0);
    run_pass("stall", {5{24'h04E000}}, 1'b1, -1, 0);

    fill_rows({24'h001000, 24'hFFF000, 24'h002000, 24'h000000, 24'hFFF800}, 24'h000000);
    hmem[5] = 24'h001000;
    run_pass("sign", {24'h001000, 24'hFFF000, 24'h002000, 24'h000000, 24'hFFF800}, 1'b0, -1, 0);

    fill_rows({5{24'h100000}}, 24'h100000);
    run_pass("sat", {5{SAT_EXP}}, 1'b0, -1, 0);

    fill_rows({5{24'h001000}}, 24'h000800);
    run_pass("bp", {5{24'h04E000}}, 1'b0, -1, 20);
    run_pass("abort", '0, 1'b0, 70, 0);
    run_pass("after_rst", {5{24'h04E000}}, 1'b0, -1, 0);

    for (int k = 0; k < 3; k++) begin
      fill_random();
      run_pass("rand", model_result(), k != 0, -1, 0);
    end

    repeat (3) @(negedge clk);
    check("queue_empty", YW'(exp_q.size()), YW'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/wo_mac_sched.md
# wo_mac_sched

Sequencer and MAC scheduler for the output-layer weight ROM of the LSTM network. It steps the ROM address over all rows. For each row it pairs one hidden-state element taken from a valid/ready stream with the `UNITS_NUM` weights returned for that row. It accumulates `UNITS_NUM` fixed-point dot products and presents them as one output word under a valid/ready handshake. It sits between the LSTM hidden-state stream and the output activation stage, and drives the ROM's 8-bit `addr` input.

## Interface

**Parameters**
- `D_WL`, 24: data word length, signed two's complement fixed point.
- `FRAC`, 12: fractional bits of `D_WL` words.
- `UNITS_NUM`, 5: output units, i.e. weights per ROM row.
- `DEPTH`, 156: ROM rows, equal to hidden elements per pass.
- `ADDR_W`, 8: ROM address width.
- Localparam `ACC_WL` = 2*`D_WL`-`FRAC`+8 (44 at defaults).

**Ports**
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: begin a pass; sampled only in IDLE.
- `busy`, output, 1: high in every state except IDLE.
- `done`, output, 1: one-cycle pulse when the result handshake completes.
- `w_addr`, output, `ADDR_W`: registered ROM address.
- `w_data`, input, `UNITS_NUM*D_WL`: combinational ROM data for `w_addr`. Unit 0 occupies the MSBs.
- `h_data`, input, `D_WL`: hidden element for the current row.
- `h_valid`, input, 1: upstream valid.
- `h_ready`, output, 1: accept for the hidden stream.
- `y_data`, output, `UNITS_NUM*D_WL`: results, unit 0 in the MSBs.
- `y_valid`, output, 1: result valid.
- `y_ready`, input, 1: downstream accept.

## Operation

**States:** IDLE, RUN, DRAIN, OUT.
- **IDLE:**
  - On `start`, clear all accumulators, the product pipeline and `w_addr`, then go to RUN.
- **RUN:**
  - `h_ready`=1.
  - On `h_valid&&h_ready`:
    - Register `UNITS_NUM` products `h_data*w_data[u]` (signed, 2*`D_WL`), arithmetically shifted right by `FRAC` and sign-extended to `ACC_WL`.
    - Set `p_vld`=1.
    - If `w_addr`==`DEPTH`-1, go to DRAIN and hold `w_addr`. Otherwise increment `w_addr`.
  - Without a handshake: `w_addr` holds and `p_vld`=0.
- **Accumulation:**
  - In any cycle with `p_vld`=1, `acc[u]` += `prod[u]`.
  - The accumulator is `ACC_WL` wide and wraps on overflow. `ACC_WL` cannot overflow for `DEPTH`≤256.
- **DRAIN:**
  - `h_ready`=0.
  - Lasts exactly one cycle, in which the final product is absorbed. Then go to OUT.
- **OUT:**
  - `y_valid`=1. `y_data` is the registered conversion of the accumulators (see Configuration).
  - `y_data` is stable while `y_valid&&!y_ready`.
  - On `y_ready`: pulse `done`, drop `y_valid` and go to IDLE.
- **Ignored inputs:**
  - `start` outside IDLE is ignored.
  - `h_valid` outside RUN is ignored.
- **Reset:**
  - `rst` has priority in every state, including mid-pass: the state returns to IDLE.
  - Partial accumulations are discarded. No `done` pulse is emitted.

## Timing

- **Reset values:**
  - `busy`, `done`, `h_ready`, `y_valid` = 0.
  - `w_addr` = 0, `y_data` = 0, accumulators = 0.
- **Per-row cycle:**
  - `w_addr` is valid at the start of the handshake cycle, because the ROM is combinational.
  - The product is registered at the end of that cycle.
  - It is accumulated at the end of the following cycle.
- **Latency with no stalls:**
  - `start` at cycle 0 gives RUN at cycle 1.
  - The last handshake occurs at cycle `DEPTH`.
  - DRAIN is at cycle `DEPTH`+1.
  - `y_valid` rises at cycle `DEPTH`+2 (158 at defaults).
- **Throughput:** one row per cycle. Stalls on `h_valid`=0 add cycles one-for-one without changing the result.
- **Wrap:** `w_addr` never exceeds `DEPTH`-1 and never wraps to 0 inside a pass.
- **Back-to-back passes:** a `start` in the cycle after `done` begins a new pass, giving a minimum gap of 1 cycle.

## Configuration

- Macro: `WO_SAT_EN`.
- **Defined:** each `acc[u]` is saturated to the signed `D_WL` range, [-2^(`D_WL`-1), 2^(`D_WL`-1)-1], when converted to `y_data`.
- **Undefined:** `y_data` takes the low `D_WL` bits of each accumulator (wrap), and no saturation logic is built.
- The accumulator itself is identical in both builds.

## Test plan

1. **Basic pass.**
   - Stimulus: bench ROM model returns 0x001000 (1.0) for all units; `h_data`=0x000800 (0.5) for all 156 rows; `y_ready`=1.
   - Required: every unit's `y_data` field = 0x04E000 (78.0).
   - Required: `y_valid` rises exactly 158 cycles after `start`; `done` pulses 1 cycle.
2. **Stalls.**
   - Stimulus: same data as scenario 1, with `h_valid` toggled in a pseudo-random pattern at 50% duty.
   - Required: identical `y_data`.
   - Required: `w_addr` advances only on handshakes; latency equals 158 plus the number of stall cycles.
3. **Per-unit sign and ordering.**
   - Stimulus: row r returns unit weights {+1.0, -1.0, +2.0, 0, -0.5}; `h_data`=1.0 only at row 5 and 0 elsewhere.
   - Required: `y_data` = {0x001000, 0xFFF000, 0x002000, 0x000000, 0xFFF800}.
4. **Saturation.**
   - Stimulus: `w_data`=0x100000 and `h_data`=0x100000 in every lane and row.
   - Required with `WO_SAT_EN`: every field = 0x7FFFFF.
   - Required without `WO_SAT_EN`: every field = 0x000000.
5. **Output backpressure.**
   - Stimulus: hold `y_ready`=0 for 20 cycles after `y_valid` rises.
   - Required: `y_data` stable and `y_valid` high throughout; `done` only in the accepting cycle.
   - Required: a `start` pulsed during OUT is ignored.
6. **Mid-pass reset.**
   - Stimulus: assert `rst` for 1 cycle at row 70, then run scenario 1.
   - Required: all outputs return to their reset values the cycle after reset.
   - Required: the new pass result is 0x04E000 per unit.
